// File: rtl/stream_demux_4.sv
// stream_demux_4: registered 1-to-4 stream demultiplexer.
// An accepted input beat is written into the 2-entry FIFO of the channel
// named by in_sel. Each channel drains independently, so a stalled consumer
// only ever blocks beats addressed to its own channel.
module stream_demux_4 #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [1:0]            in_sel,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out0_data,
   output logic [DATA_WIDTH-1:0] out1_data,
   output logic [DATA_WIDTH-1:0] out2_data,
   output logic [DATA_WIDTH-1:0] out3_data,
   output logic [3:0]            out_valid,
   input  logic [3:0]            out_ready
);

   logic [3:0][1:0][DATA_WIDTH-1:0] mem_q, mem_d;
   logic [3:0][1:0]                 cnt_q, cnt_d;
   logic [3:0]                      wptr_q, wptr_d;
   logic [3:0]                      rptr_q, rptr_d;
   logic [3:0]                      push_vec;
   logic [3:0]                      pop_vec;
   logic [3:0][DATA_WIDTH-1:0]      head_data;

   // A full channel refuses input even when it is popped in the same cycle;
   // in_ready therefore looks only at the registered count of the selected channel.
   assign in_ready = (cnt_q[in_sel] != 2'd2);

   // Next-state computation: route the accepted beat, advance pointers, update occupancy.
   always_comb begin
      mem_d    = mem_q;
      cnt_d    = cnt_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      push_vec = '0;
      pop_vec  = '0;
      for (int i = 0; i < 4; i++) begin
         push_vec[i] = in_valid && in_ready && (in_sel == 2'(i));
         pop_vec[i]  = (cnt_q[i] != 2'd0) && out_ready[i];
         if (push_vec[i]) begin
            mem_d[i][wptr_q[i]] = in_data;
            wptr_d[i]           = ~wptr_q[i];
         end
         if (pop_vec[i]) begin
            rptr_d[i] = ~rptr_q[i];
         end
         case ({push_vec[i], pop_vec[i]})
            2'b10:   cnt_d[i] = cnt_q[i] + 2'd1;
            2'b01:   cnt_d[i] = cnt_q[i] - 2'd1;
            default: cnt_d[i] = cnt_q[i];
         endcase
      end
   end

   // State registers; reset discards every buffered beat and ignores any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q  <= '0;
         cnt_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         mem_q  <= mem_d;
         cnt_q  <= cnt_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Head-of-FIFO view per channel, forced to zero when the channel is empty
   // so stale data left in a freed entry never shows on the bus.
   always_comb begin
      out_valid = '0;
      head_data = '0;
      for (int i = 0; i < 4; i++) begin
         out_valid[i] = (cnt_q[i] != 2'd0);
         head_data[i] = (cnt_q[i] != 2'd0) ? mem_q[i][rptr_q[i]] : '0;
      end
   end

   assign out0_data = head_data[0];
   assign out1_data = head_data[1];
   assign out2_data = head_data[2];
   assign out3_data = head_data[3];

endmodule

// File: tb/tb_stream_demux_4.sv
// tb_stream_demux_4: directed, self-checking bench for stream_demux_4.
// Inputs change 1 time unit after the rising edge; outputs are observed
// before the next rising edge.
module tb_stream_demux_4;

   logic       clk;
   logic       rst;
   logic [7:0] in_data;
   logic [1:0] in_sel;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out0_data;
   logic [7:0] out1_data;
   logic [7:0] out2_data;
   logic [7:0] out3_data;
   logic [3:0] out_valid;
   logic [3:0] out_ready;

   int testsRun;
   int testsFailed;

   stream_demux_4 #(.DATA_WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out0_data (out0_data),
      .out1_data (out1_data),
      .out2_data (out2_data),
      .out3_data (out3_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Set producer-side inputs and let combinational in_ready settle.
   task automatic applyStimulus(input logic valid, input logic [1:0] sel,
                                input logic [7:0] data);
      in_valid = valid;
      in_sel   = sel;
      in_data  = data;
      #1;
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   // Directed sequence with hand-computed expectations.
   initial begin
      testsRun    = 0;
      testsFailed = 0;
      out_ready   = 4'b0000;
      rst         = 1'b1;
      applyStimulus(1'b1, 2'd0, 8'hAA);

      // Reset held two cycles with a beat offered.
      stepClock();
      stepClock();
      checkOutput("rst_valid", out_valid, 4'b0000);
      checkOutput("rst_d0", out0_data, 8'h00);
      checkOutput("rst_d1", out1_data, 8'h00);
      checkOutput("rst_d2", out2_data, 8'h00);
      checkOutput("rst_d3", out3_data, 8'h00);
      checkOutput("rst_ready", in_ready, 1'b1);
      rst = 1'b0;
      applyStimulus(1'b0, 2'd0, 8'h00);
      stepClock();
      checkOutput("post_rst_valid", out_valid, 4'b0000);

      // Routing with every consumer ready.
      out_ready = 4'b1111;
      applyStimulus(1'b1, 2'd0, 8'h10);
      stepClock();
      checkOutput("route0_valid", out_valid, 4'b0001);
      checkOutput("route0_data", out0_data, 8'h10);
      applyStimulus(1'b1, 2'd1, 8'h21);
      stepClock();
      checkOutput("route1_valid", out_valid, 4'b0010);
      checkOutput("route1_data", out1_data, 8'h21);
      applyStimulus(1'b1, 2'd2, 8'h32);
      stepClock();
      checkOutput("route2_valid", out_valid, 4'b0100);
      checkOutput("route2_data", out2_data, 8'h32);
      applyStimulus(1'b1, 2'd3, 8'h43);
      stepClock();
      checkOutput("route3_valid", out_valid, 4'b1000);
      checkOutput("route3_data", out3_data, 8'h43);
      applyStimulus(1'b0, 2'd0, 8'h00);
      stepClock();
      checkOutput("route_drain", out_valid, 4'b0000);

      // Backpressure on channel 2.
      out_ready = 4'b1011;
      applyStimulus(1'b1, 2'd2, 8'h01);
      checkOutput("bp_ready1", in_ready, 1'b1);
      stepClock();
      applyStimulus(1'b1, 2'd2, 8'h02);
      checkOutput("bp_ready2", in_ready, 1'b1);
      stepClock();
      applyStimulus(1'b1, 2'd2, 8'h03);
      checkOutput("bp_ready3_full", in_ready, 1'b0);
      checkOutput("bp_valid_full", out_valid, 4'b0100);
      checkOutput("bp_head01", out2_data, 8'h01);
      stepClock();
      checkOutput("bp_still_full", in_ready, 1'b0);
      checkOutput("bp_head01_hold", out2_data, 8'h01);
      out_ready = 4'b1111;
      #1;
      checkOutput("bp_ready_no_passthru", in_ready, 1'b0);
      stepClock();
      checkOutput("bp_ready_after_pop", in_ready, 1'b1);
      checkOutput("bp_head02", out2_data, 8'h02);
      stepClock();
      checkOutput("bp_head03", out2_data, 8'h03);
      checkOutput("bp_valid03", out_valid, 4'b0100);
      applyStimulus(1'b0, 2'd0, 8'h00);
      stepClock();
      checkOutput("bp_drain", out_valid, 4'b0000);

      // Isolation: channel 1 full and stalled while 0 and 3 stream at full rate.
      out_ready = 4'b1101;
      applyStimulus(1'b1, 2'd1, 8'h60);
      stepClock();
      applyStimulus(1'b1, 2'd1, 8'h61);
      stepClock();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, (i % 2 == 0) ? 2'd0 : 2'd3, 8'h50 + 8'(i));
         checkOutput("iso_ready", in_ready, 1'b1);
         stepClock();
         if (i % 2 == 0) begin
            checkOutput("iso_d0", out0_data, 8'h50 + 8'(i));
            checkOutput("iso_valid_even", out_valid, 4'b0011);
         end else begin
            checkOutput("iso_d3", out3_data, 8'h50 + 8'(i));
            checkOutput("iso_valid_odd", out_valid, 4'b1010);
         end
         checkOutput("iso_d1_hold", out1_data, 8'h60);
      end
      applyStimulus(1'b1, 2'd1, 8'h99);
      checkOutput("iso_ch1_refuse", in_ready, 1'b0);
      applyStimulus(1'b0, 2'd0, 8'h00);
      stepClock();
      checkOutput("iso_only_ch1", out_valid, 4'b0010);
      out_ready = 4'b1111;
      stepClock();
      checkOutput("iso_d1_second", out1_data, 8'h61);
      stepClock();
      checkOutput("iso_drain", out_valid, 4'b0000);

      // Simultaneous push and pop on channel 0.
      out_ready = 4'b0000;
      applyStimulus(1'b1, 2'd0, 8'hC0);
      stepClock();
      checkOutput("pp_headC0", out0_data, 8'hC0);
      out_ready = 4'b0001;
      applyStimulus(1'b1, 2'd0, 8'hC1);
      stepClock();
      checkOutput("pp_headC1", out0_data, 8'hC1);
      checkOutput("pp_valid", out_valid, 4'b0001);
      out_ready = 4'b0000;
      applyStimulus(1'b1, 2'd0, 8'hC2);
      checkOutput("pp_ready_cnt1", in_ready, 1'b1);
      stepClock();
      out_ready = 4'b0001;
      applyStimulus(1'b1, 2'd0, 8'hC3);
      checkOutput("pp_ready_cnt2", in_ready, 1'b0);
      stepClock();
      checkOutput("pp_headC2", out0_data, 8'hC2);
      applyStimulus(1'b0, 2'd0, 8'h00);
      stepClock();
      checkOutput("pp_drain", out_valid, 4'b0000);
      checkOutput("pp_masked", out0_data, 8'h00);

      // Reset in the middle of operation.
      out_ready = 4'b0000;
      applyStimulus(1'b1, 2'd0, 8'hA0);
      stepClock();
      applyStimulus(1'b1, 2'd0, 8'hA1);
      stepClock();
      applyStimulus(1'b1, 2'd3, 8'hB0);
      stepClock();
      applyStimulus(1'b1, 2'd3, 8'hB1);
      stepClock();
      checkOutput("mid_filled", out_valid, 4'b1001);
      rst = 1'b1;
      applyStimulus(1'b0, 2'd0, 8'h00);
      stepClock();
      rst = 1'b0;
      checkOutput("mid_rst_valid", out_valid, 4'b0000);
      checkOutput("mid_rst_d0", out0_data, 8'h00);
      checkOutput("mid_rst_d3", out3_data, 8'h00);
      out_ready = 4'b1111;
      applyStimulus(1'b1, 2'd0, 8'hD0);
      stepClock();
      checkOutput("mid_d0_fresh", out0_data, 8'hD0);
      applyStimulus(1'b1, 2'd3, 8'hD3);
      stepClock();
      checkOutput("mid_d3_fresh", out3_data, 8'hD3);
      checkOutput("mid_valid", out_valid, 4'b1000);
      applyStimulus(1'b0, 2'd0, 8'h00);
      stepClock();
      checkOutput("mid_drain", out_valid, 4'b0000);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
